// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// stop-bit polarity, stage indices and the multi-cycle EX FSM encoding.
package pipe_stall_ctrl_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Bit positions inside the stop vector, PC first, WB last.
    typedef enum int {
        STG_PC  = 0,
        STG_IF  = 1,
        STG_ID  = 2,
        STG_EX  = 3,
        STG_MEM = 4,
        STG_WB  = 5
    } stg_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    // Stop vector holding every stage from PC up to and including 'last'.
    function automatic logic [5:0] stop_through(input stg_e last);
        logic [5:0] v;
        for (int i = int'(STG_PC); i <= int'(STG_WB); i++) begin
            v[i] = (i <= int'(last)) ? STOP : NOSTOP;
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_ex_mc_seq.sv
// Multi-cycle EX sequencer: 2-cycle madd/msub phasing and the divider
// handshake, including the timeout watchdog and the sticky error flag.
module pipe_stall_ctrl_ex_mc_seq
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stallreq_mem,
    input  logic flush_req,
    input  logic ex_mac_req,
    input  logic ex_div_req,
    input  logic div_ready,
    output logic stallreq_ex,
    output logic ex_cnt,
    output logic div_start,
    output logic div_cancel,
    output logic div_err
);

    localparam int TMR_W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DIV_TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic             err_q;
    logic             timeout_hit;

    // Decode outputs from the current state; the timeout only fires on a cycle
    // where the FSM is actually allowed to move (no MEM freeze, no flush).
    always_comb begin
        timeout_hit = (state == S_DIV) && (timer == TMR_LAST) && !div_ready
                      && !stallreq_mem && !flush_req;
        stallreq_ex = ((state == S_IDLE) && (ex_mac_req || ex_div_req))
                      || ((state == S_DIV) && !div_ready && !timeout_hit);
        ex_cnt      = (state == S_MAC);
        div_start   = (state == S_DIV);
        div_cancel  = (state == S_DIV) && (flush_req || timeout_hit);
        div_err     = err_q || timeout_hit;
    end

    // Next-state logic: flush overrides everything, a MEM stall freezes the FSM.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        if (flush_req) begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
        end else if (!stallreq_mem) begin
            case (state)
                S_IDLE: begin
                    timer_nxt = '0;
                    if (ex_mac_req) begin
                        state_nxt = S_MAC;
                    end else if (ex_div_req) begin
                        state_nxt = S_DIV;
                    end
                end
                S_MAC: begin
                    state_nxt = S_IDLE;
                end
                S_DIV: begin
                    if (div_ready || timeout_hit) begin
                        state_nxt = S_IDLE;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TMR_W'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // State, division timer and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            timer <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            err_q <= err_q | timeout_hit;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Optional feature: define STALL_PERF_EN to build the stall_cycles counter;
// without it stall_cycles is tied to zero.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 40,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stallreq_id,
    input  logic              stallreq_mem,
    input  logic              ex_mac_req,
    input  logic              ex_div_req,
    input  logic              div_ready,
    input  logic              flush_req,
    output logic [5:0]        stop,
    output logic              flush,
    output logic              ex_cnt,
    output logic              div_start,
    output logic              div_cancel,
    output logic              div_err,
    output logic [PERF_W-1:0] stall_cycles
);

    logic stallreq_ex;

    pipe_stall_ctrl_ex_mc_seq #(
        .DIV_TIMEOUT (DIV_TIMEOUT)
    ) u_ex_mc_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallreq_mem (stallreq_mem),
        .flush_req    (flush_req),
        .ex_mac_req   (ex_mac_req),
        .ex_div_req   (ex_div_req),
        .div_ready    (div_ready),
        .stallreq_ex  (stallreq_ex),
        .ex_cnt       (ex_cnt),
        .div_start    (div_start),
        .div_cancel   (div_cancel),
        .div_err      (div_err)
    );

    // Stall priority mux; everything is held quiet while reset is asserted.
    always_comb begin
        stop  = {6{NOSTOP}};
        flush = 1'b0;
        if (rst_n) begin
            if (flush_req) begin
                flush = 1'b1;
            end else if (stallreq_mem) begin
                stop = stop_through(STG_MEM);
            end else if (stallreq_ex) begin
                stop = stop_through(STG_EX);
            end else if (stallreq_id) begin
                stop = stop_through(STG_ID);
            end
        end
    end

`ifdef STALL_PERF_EN
    logic [PERF_W-1:0] stall_cnt;

    // Saturating count of cycles in which the PC is held; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((stop[STG_PC] == STOP) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl (scoreboard of per-cycle expectations).
module tb_pipe_stall_ctrl;

    localparam int DIV_TIMEOUT = 40;
    localparam int PERF_W      = 32;

    // Input encoding for the stimulus task: {flush, mem, id, mac, div, ready}
    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_RDY  = 6'b000001;
    localparam logic [5:0] I_DIV  = 6'b000010;
    localparam logic [5:0] I_MAC  = 6'b000100;
    localparam logic [5:0] I_ID   = 6'b001000;
    localparam logic [5:0] I_MEM  = 6'b010000;
    localparam logic [5:0] I_FL   = 6'b100000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stallreq_id, stallreq_mem, ex_mac_req, ex_div_req, div_ready, flush_req;
    logic [5:0]        stop;
    logic              flush, ex_cnt, div_start, div_cancel, div_err;
    logic [PERF_W-1:0] stall_cycles;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .DIV_TIMEOUT (DIV_TIMEOUT),
        .PERF_W      (PERF_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .ex_mac_req   (ex_mac_req),
        .ex_div_req   (ex_div_req),
        .div_ready    (div_ready),
        .flush_req    (flush_req),
        .stop         (stop),
        .flush        (flush),
        .ex_cnt       (ex_cnt),
        .div_start    (div_start),
        .div_cancel   (div_cancel),
        .div_err      (div_err),
        .stall_cycles (stall_cycles)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string      tag;
        logic [10:0] v;
    } exp_t;

    exp_t sb[$];
    logic exp_err;
    int   exp_stalls;

    wire [10:0] obs_v = {stop, flush, ex_cnt, div_start, div_cancel, div_err};

    function automatic logic [10:0] o(input logic [5:0] s, input logic f, input logic c,
                                      input logic st, input logic cn);
        return {s, f, c, st, cn, exp_err};
    endfunction

    // Drive one cycle of inputs, queue its expected outputs, compare at the negedge.
    task automatic cyc(input string tag, input logic [5:0] in, input logic [10:0] e);
        exp_t x;
        {flush_req, stallreq_mem, stallreq_id, ex_mac_req, ex_div_req, div_ready} = in;
        x.tag = tag;
        x.v   = e;
        sb.push_back(x);
        @(negedge clk);
        x = sb.pop_front();
        check(x.tag, {21'd0, obs_v}, {21'd0, x.v});
        if (x.v[5]) exp_stalls++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_perf(input string tag);
`ifdef STALL_PERF_EN
        check(tag, stall_cycles, exp_stalls);
`else
        check(tag, stall_cycles, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_err    = 1'b0;
        exp_stalls = 0;
        {flush_req, stallreq_mem, stallreq_id, ex_mac_req, ex_div_req, div_ready} = I_FL | I_MEM | I_MAC;
        #12;
        check("rst_outputs", {21'd0, obs_v}, 32'd0);
        check("rst_perf", stall_cycles, 32'd0);
        {flush_req, stallreq_mem, stallreq_id, ex_mac_req, ex_div_req, div_ready} = I_NONE;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc("idle", I_NONE, o(6'b000000, 0, 0, 0, 0));
        cyc("id_stall", I_ID, o(6'b000111, 0, 0, 0, 0));
        cyc("id_after", I_NONE, o(6'b000000, 0, 0, 0, 0));
        chk_perf("perf_id");

        cyc("mac0", I_MAC, o(6'b001111, 0, 0, 0, 0));
        cyc("mac1", I_MAC, o(6'b000000, 0, 1, 0, 0));
        cyc("mac_idle", I_NONE, o(6'b000000, 0, 0, 0, 0));

        cyc("mac_mem", I_MAC | I_MEM, o(6'b011111, 0, 0, 0, 0));
        cyc("mac_go", I_MAC, o(6'b001111, 0, 0, 0, 0));
        cyc("mac_acc", I_MAC, o(6'b000000, 0, 1, 0, 0));
        cyc("ex_over_id", I_MAC | I_ID, o(6'b001111, 0, 0, 0, 0));
        cyc("mac_acc_id", I_MAC | I_ID, o(6'b000111, 0, 1, 0, 0));
        cyc("mac_idle2", I_NONE, o(6'b000000, 0, 0, 0, 0));

        cyc("div_req", I_DIV, o(6'b001111, 0, 0, 0, 0));
        for (int i = 1; i <= 32; i++)
            cyc($sformatf("div_wait%0d", i), I_DIV, o(6'b001111, 0, 0, 1, 0));
        cyc("div_rdy", I_DIV | I_RDY, o(6'b000000, 0, 0, 1, 0));
        cyc("div_done", I_NONE, o(6'b000000, 0, 0, 0, 0));
        chk_perf("perf_div");

        cyc("dm_req", I_DIV, o(6'b001111, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++)
            cyc($sformatf("dm_wait%0d", i), I_DIV, o(6'b001111, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            cyc($sformatf("dm_rdy_mem%0d", i), I_DIV | I_RDY | I_MEM, o(6'b011111, 0, 0, 1, 0));
        cyc("dm_rdy_go", I_DIV | I_RDY, o(6'b000000, 0, 0, 1, 0));
        cyc("b2b_bubble", I_DIV, o(6'b001111, 0, 0, 0, 0));
        cyc("b2b_div", I_DIV, o(6'b001111, 0, 0, 1, 0));
        cyc("b2b_rdy", I_DIV | I_RDY, o(6'b000000, 0, 0, 1, 0));
        cyc("b2b_idle", I_NONE, o(6'b000000, 0, 0, 0, 0));

        cyc("fd_req", I_DIV, o(6'b001111, 0, 0, 0, 0));
        for (int i = 1; i <= 9; i++)
            cyc($sformatf("fd_wait%0d", i), I_DIV, o(6'b001111, 0, 0, 1, 0));
        cyc("fd_flush", I_FL | I_DIV | I_RDY, o(6'b000000, 1, 0, 1, 1));
        cyc("fd_after", I_NONE, o(6'b000000, 0, 0, 0, 0));
        cyc("fm_mac", I_MAC, o(6'b001111, 0, 0, 0, 0));
        cyc("fm_flush", I_FL | I_MAC, o(6'b000000, 1, 1, 0, 0));
        cyc("fm_after", I_NONE, o(6'b000000, 0, 0, 0, 0));
        cyc("fi_flush", I_FL | I_MAC, o(6'b000000, 1, 0, 0, 0));
        cyc("fi_after", I_NONE, o(6'b000000, 0, 0, 0, 0));
        cyc("fl_over_mem", I_FL | I_MEM | I_ID, o(6'b000000, 1, 0, 0, 0));

        for (int i = 0; i < 5; i++)
            cyc($sformatf("perf_stall%0d", i), I_ID, o(6'b000111, 0, 0, 0, 0));
        cyc("perf_idle", I_NONE, o(6'b000000, 0, 0, 0, 0));
        chk_perf("perf_five");

        cyc("to_req", I_DIV, o(6'b001111, 0, 0, 0, 0));
        for (int t = 0; t < DIV_TIMEOUT - 1; t++)
            cyc($sformatf("to_wait%0d", t), I_DIV, o(6'b001111, 0, 0, 1, 0));
        exp_err = 1'b1;
        cyc("timeout", I_DIV, o(6'b000000, 0, 0, 1, 1));
        cyc("to_after", I_NONE, o(6'b000000, 0, 0, 0, 0));
        cyc("to_sticky", I_ID, o(6'b000111, 0, 0, 0, 0));
        chk_perf("perf_timeout");

        cyc("ar_req", I_DIV, o(6'b001111, 0, 0, 0, 0));
        for (int i = 1; i <= 3; i++)
            cyc($sformatf("ar_wait%0d", i), I_DIV, o(6'b001111, 0, 0, 1, 0));
        {flush_req, stallreq_mem, stallreq_id, ex_mac_req, ex_div_req, div_ready} = I_DIV | I_ID;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_outputs", {21'd0, obs_v}, 32'd0);
        check("arst_perf", stall_cycles, 32'd0);
        exp_err    = 1'b0;
        exp_stalls = 0;
        {flush_req, stallreq_mem, stallreq_id, ex_mac_req, ex_div_req, div_ready} = I_NONE;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("post_rst", I_NONE, o(6'b000000, 0, 0, 0, 0));
        chk_perf("perf_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
